dmem_arbiter: RTL and testbench

- Shares the single data memory port between two requesters: the pipeline MEM stage (EX/MEM load/store) and a debug/loader port used for program-data preload and run-time inspection.
- The pipeline has priority. A starvation counter bounds how long the debug port can wait; once it expires, the arbiter stalls the pipeline for one forced debug slot.
- Sits between the EX/MEM register outputs and datamemory.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the pipeline, debug and data-memory signals around the arbiter.
// slave is the arbiter side; master is the side that drives the requests and the memory.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  p_req;
  logic                  p_we;
  logic [DM_ADDRESS-1:0] p_addr;
  logic [DATA_W-1:0]     p_wdata;
  logic [2:0]            p_funct3;
  logic [DATA_W-1:0]     p_rdata;
  logic                  p_stall;

  logic                  d_req;
  logic                  d_we;
  logic [DM_ADDRESS-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [2:0]            d_funct3;
  logic                  d_ack;
  logic [DATA_W-1:0]     d_rdata;

  logic                  m_read;
  logic                  m_write;
  logic [DM_ADDRESS-1:0] m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [2:0]            m_funct3;
  logic [DATA_W-1:0]     m_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, p_funct3,
    input  d_req, d_we, d_addr, d_wdata, d_funct3,
    input  m_rdata,
    output p_rdata, p_stall, d_ack, d_rdata,
    output m_read, m_write, m_addr, m_wdata, m_funct3
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata, p_funct3,
    output d_req, d_we, d_addr, d_wdata, d_funct3,
    output m_rdata,
    input  p_rdata, p_stall, d_ack, d_rdata,
    input  m_read, m_write, m_addr, m_wdata, m_funct3
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: pipeline MEM stage has priority, debug/loader port
// gets a forced slot after STARVE_LIM consecutive lost cycles.
//
// state   | meaning
// S_IDLE  | pipeline priority; debug served only when the pipeline is idle
// S_FORCE | debug starved; debug takes the port and the pipeline is stalled
// S_ACK   | debug access done; d_ack high, debug not eligible this cycle
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 3
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FORCE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STARVE_LIM - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             grant_p, grant_d;
  logic             d_ack_q;
  logic [DATA_W-1:0] d_rdata_q;

  always_comb begin
    grant_p   = 1'b0;
    grant_d   = 1'b0;
    state_nxt = S_IDLE;
    cnt_nxt   = '0;
    case (state)
      S_IDLE: begin
        grant_p = bus.p_req;
        grant_d = ~bus.p_req & bus.d_req;
        if (bus.p_req && bus.d_req) begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = (cnt == LIM_M1) ? S_FORCE : S_IDLE;
        end else if (grant_d) begin
          state_nxt = S_ACK;
        end
      end
      S_FORCE: begin
        // A withdrawn debug request hands the cycle straight back to the pipeline.
        grant_d   = bus.d_req;
        grant_p   = ~bus.d_req & bus.p_req;
        state_nxt = bus.d_req ? S_ACK : S_IDLE;
      end
      S_ACK: begin
        grant_p = bus.p_req;
      end
      default: begin
        grant_p = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.m_read   = 1'b0;
    bus.m_write  = 1'b0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.m_funct3 = '0;
    if (grant_d) begin
      bus.m_read   = ~bus.d_we;
      bus.m_write  = bus.d_we;
      bus.m_addr   = bus.d_addr;
      bus.m_wdata  = bus.d_wdata;
      bus.m_funct3 = bus.d_funct3;
    end else if (grant_p) begin
      bus.m_read   = ~bus.p_we;
      bus.m_write  = bus.p_we;
      bus.m_addr   = bus.p_addr;
      bus.m_wdata  = bus.p_wdata;
      bus.m_funct3 = bus.p_funct3;
    end
  end

  assign bus.p_rdata = grant_p ? bus.m_rdata : '0;
  assign bus.p_stall = (state == S_FORCE) & bus.d_req;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_rdata = d_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      d_ack_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      d_ack_q <= grant_d;
      if (grant_d && !bus.d_we) begin
        d_rdata_q <= bus.m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for the single-cycle behaviour
// and hand-written sequences for the withdrawn forced slot and reset during it.
module tb_dmem_arbiter;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FORCE = 2'd1;
  localparam logic [2:0] PF3 = 3'b010;
  localparam logic [2:0] DF3 = 3'b100;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] mem [0:127];

  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_LIM(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide memory model: combinational read, write at the rising edge.
  assign bus.m_rdata = bus.m_read ? mem[bus.m_addr[8:2]] : 32'h0;
  always @(posedge clk) if (bus.m_write) mem[bus.m_addr[8:2]] <= bus.m_wdata;

  typedef struct {
    logic        p_req, p_we;
    logic [8:0]  p_addr;
    logic [31:0] p_wdata;
    logic        d_req, d_we;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic        e_read, e_write;
    logic [8:0]  e_addr;
    logic [31:0] e_wdata;
    logic [2:0]  e_f3;
    logic        e_stall;
    logic [31:0] e_prdata;
    logic        e_ack;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs [0:13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pr, input logic pw, input logic [8:0] pa, input logic [31:0] pd,
                       input logic dr, input logic dw, input logic [8:0] da, input logic [31:0] dd);
    bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd; bus.p_funct3 = PF3;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd; bus.d_funct3 = DF3;
  endtask

  function automatic vec_t mk(logic pr, logic pw, logic [8:0] pa, logic [31:0] pd,
                              logic dr, logic dw, logic [8:0] da, logic [31:0] dd,
                              logic er, logic ew, logic [8:0] ea, logic [31:0] ewd, logic [2:0] ef,
                              logic es, logic [31:0] ep, logic ek, logic [31:0] edr);
    vec_t v;
    v.p_req = pr; v.p_we = pw; v.p_addr = pa; v.p_wdata = pd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.e_read = er; v.e_write = ew; v.e_addr = ea; v.e_wdata = ewd; v.e_f3 = ef;
    v.e_stall = es; v.e_prdata = ep; v.e_ack = ek; v.e_drdata = edr;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;

    vecs[0]  = mk(0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        3'b000, 0,32'h0,        0,32'h0);
    vecs[1]  = mk(1,1,9'h010,32'hDEADBEEF, 0,0,9'h000,32'h0,        0,1,9'h010,32'hDEADBEEF, PF3,    0,32'h0,        0,32'h0);
    vecs[2]  = mk(1,0,9'h010,32'h0,        0,0,9'h000,32'h0,        1,0,9'h010,32'h0,        PF3,    0,32'hDEADBEEF, 0,32'h0);
    vecs[3]  = mk(0,0,9'h000,32'h0,        1,0,9'h010,32'h0,        1,0,9'h010,32'h0,        DF3,    0,32'h0,        0,32'h0);
    vecs[4]  = mk(0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        3'b000, 0,32'h0,        1,32'hDEADBEEF);
    vecs[5]  = mk(0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        3'b000, 0,32'h0,        0,32'hDEADBEEF);
    for (int i = 6; i <= 9; i++)
      vecs[i] = mk(1,0,9'h010,32'h0,       1,1,9'h030,32'hCAFEF00D, 1,0,9'h010,32'h0,        PF3,    0,32'hDEADBEEF, 0,32'hDEADBEEF);
    vecs[10] = mk(1,0,9'h010,32'h0,        1,1,9'h030,32'hCAFEF00D, 0,1,9'h030,32'hCAFEF00D, DF3,    1,32'h0,        0,32'hDEADBEEF);
    vecs[11] = mk(1,0,9'h010,32'h0,        1,1,9'h030,32'hCAFEF00D, 1,0,9'h010,32'h0,        PF3,    0,32'hDEADBEEF, 1,32'hDEADBEEF);
    vecs[12] = mk(0,0,9'h000,32'h0,        1,0,9'h030,32'h0,        1,0,9'h030,32'h0,        DF3,    0,32'h0,        0,32'hDEADBEEF);
    vecs[13] = mk(0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        0,0,9'h000,32'h0,        3'b000, 0,32'h0,        1,32'hCAFEF00D);

    reset = 1'b0;
    drive(0,0,9'h0,32'h0, 0,0,9'h0,32'h0);
    repeat (2) @(negedge clk);
    #2;
    chk("reset state",   32'(dut.state), 32'(ST_IDLE));
    chk("reset cnt",     32'(dut.cnt),   32'h0);
    chk("reset d_ack",   32'(bus.d_ack), 32'h0);
    chk("reset d_rdata", bus.d_rdata,    32'h0);
    chk("reset m_read",  32'(bus.m_read | bus.m_write), 32'h0);
    chk("reset p_stall", 32'(bus.p_stall), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].p_req, vecs[i].p_we, vecs[i].p_addr, vecs[i].p_wdata,
            vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata);
      #2;
      chk($sformatf("v%0d m_read", i),   32'(bus.m_read),   32'(vecs[i].e_read));
      chk($sformatf("v%0d m_write", i),  32'(bus.m_write),  32'(vecs[i].e_write));
      chk($sformatf("v%0d m_addr", i),   32'(bus.m_addr),   32'(vecs[i].e_addr));
      chk($sformatf("v%0d m_wdata", i),  bus.m_wdata,       vecs[i].e_wdata);
      chk($sformatf("v%0d m_funct3", i), 32'(bus.m_funct3), 32'(vecs[i].e_f3));
      chk($sformatf("v%0d p_stall", i),  32'(bus.p_stall),  32'(vecs[i].e_stall));
      chk($sformatf("v%0d p_rdata", i),  bus.p_rdata,       vecs[i].e_prdata);
      chk($sformatf("v%0d d_ack", i),    32'(bus.d_ack),    32'(vecs[i].e_ack));
      chk($sformatf("v%0d d_rdata", i),  bus.d_rdata,       vecs[i].e_drdata);
    end

    // Starvation, then debug withdraws its request in the forced slot.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1,0,9'h030,32'h0, 1,0,9'h010,32'h0);
      #2;
      chk($sformatf("drop c%0d p_stall", c), 32'(bus.p_stall), 32'h0);
    end
    @(negedge clk);
    drive(1,0,9'h030,32'h0, 0,0,9'h010,32'h0);
    #2;
    chk("drop force state", 32'(dut.state),   32'(ST_FORCE));
    chk("drop m_read",      32'(bus.m_read),  32'h1);
    chk("drop m_write",     32'(bus.m_write), 32'h0);
    chk("drop m_addr",      32'(bus.m_addr),  32'h030);
    chk("drop p_stall",     32'(bus.p_stall), 32'h0);
    chk("drop p_rdata",     bus.p_rdata,      32'hCAFEF00D);
    @(negedge clk);
    drive(0,0,9'h0,32'h0, 0,0,9'h0,32'h0);
    #2;
    chk("drop d_ack",   32'(bus.d_ack), 32'h0);
    chk("drop state",   32'(dut.state), 32'(ST_IDLE));
    chk("drop cnt",     32'(dut.cnt),   32'h0);
    chk("drop d_rdata", bus.d_rdata,    32'hCAFEF00D);

    // Reset lands inside a forced debug write slot.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1,0,9'h010,32'h0, 1,1,9'h020,32'h55AA55AA);
    end
    @(negedge clk);
    #2;
    chk("rst force state",   32'(dut.state),   32'(ST_FORCE));
    chk("rst force m_write", 32'(bus.m_write), 32'h1);
    reset = 1'b0;
    drive(0,0,9'h0,32'h0, 0,0,9'h0,32'h0);
    #1;
    chk("rst m_write",  32'(bus.m_write), 32'h0);
    chk("rst state",    32'(dut.state),   32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      chk($sformatf("rst c%0d d_ack", c), 32'(bus.d_ack), 32'h0);
    end
    chk("rst mem 0x020", mem[8],          32'h0);
    chk("rst post state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst d_rdata",    bus.d_rdata,    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
